// File: rtl/riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module   : riscv_lsu
// Brief    : RV32/RV64 load/store unit, single outstanding bus transaction.
//            Optional bus timeout enabled by macro RISCV_LSU_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_lsu #(
    parameter int N              = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [2:0]       fn3,
    input  logic [N-1:0]     address,
    input  logic [N-1:0]     rs2_data,
    output logic             stall,
    output logic [N-1:0]     rd_data,
    output logic             rd_valid,
    output logic             fault,
    output logic             bus_valid,
    input  logic             bus_ready,
    output logic             bus_we,
    output logic [N-1:0]     bus_addr,
    output logic [N-1:0]     bus_wdata,
    output logic [N/8-1:0]   bus_wstrb,
    input  logic [N-1:0]     bus_rdata
);
    localparam int c_OW = $clog2(N / 8);
    localparam int c_SW = N / 8;

    generate
        if (N != 32 && N != 64) begin : g_bad_width
            $error("riscv_lsu: N must be 32 or 64");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("riscv_lsu: TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [2:0]        r_fn3;
    logic              r_is_load;
    logic [c_OW-1:0]   r_off;

    logic              w_rw_one;
    logic              w_fn3_ok;
    logic [c_OW-1:0]   w_off;
    logic [c_OW-1:0]   w_amask;
    logic              w_misal;
    logic              w_idle_req;
    logic              w_go;
    logic              w_bad;
    logic [N-1:0]      w_wdata;
    logic [c_SW-1:0]   w_strb;
    logic [N-1:0]      w_lane;
    logic [N-1:0]      w_ext;

`ifdef RISCV_LSU_TIMEOUT_EN
    localparam int              c_CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CW-1:0] c_TMO_LAST = c_CW'(TIMEOUT_CYCLES - 1);
    logic [c_CW-1:0]            r_tmo_cnt;
`endif

    // Request decode: only meaningful while idle.
    always_comb begin
        w_rw_one = mem_read ^ mem_write;
        w_off    = address[c_OW-1:0];
        case (fn3)
            3'b000, 3'b001, 3'b010: w_fn3_ok = 1'b1;
            3'b100, 3'b101:         w_fn3_ok = mem_read;
            3'b011:                 w_fn3_ok = (N == 64);
            3'b110:                 w_fn3_ok = mem_read & (N == 64);
            default:                w_fn3_ok = 1'b0;
        endcase
        case (fn3[1:0])
            2'b00:   w_amask = '0;
            2'b01:   w_amask = c_OW'(1);
            2'b10:   w_amask = c_OW'(3);
            default: w_amask = c_OW'(7);
        endcase
        w_misal    = |(w_off & w_amask);
        w_idle_req = (r_state == S_IDLE) & req_valid;
        w_go       = w_idle_req & w_rw_one & w_fn3_ok & ~w_misal;
        w_bad      = w_idle_req & ((mem_read & mem_write) |
                                   (w_rw_one & (~w_fn3_ok | w_misal)));
    end

    // Store lane replication and byte enables.
    always_comb begin
        case (fn3[1:0])
            2'b00: begin
                w_wdata = {c_SW{rs2_data[7:0]}};
                w_strb  = c_SW'(1);
            end
            2'b01: begin
                w_wdata = {(N/16){rs2_data[15:0]}};
                w_strb  = c_SW'(3);
            end
            2'b10: begin
                w_wdata = {(N/32){rs2_data[31:0]}};
                w_strb  = c_SW'(15);
            end
            default: begin
                w_wdata = rs2_data;
                w_strb  = '1;
            end
        endcase
    end

    // Load lane select and extension, using the fields latched at accept.
    always_comb begin
        w_lane = bus_rdata >> {r_off, 3'b000};
        case (r_fn3)
            3'b000: begin w_ext = {N{w_lane[7]}};  w_ext[7:0]  = w_lane[7:0];  end
            3'b001: begin w_ext = {N{w_lane[15]}}; w_ext[15:0] = w_lane[15:0]; end
            3'b010: begin w_ext = {N{w_lane[31]}}; w_ext[31:0] = w_lane[31:0]; end
            3'b100: begin w_ext = '0;              w_ext[7:0]  = w_lane[7:0];  end
            3'b101: begin w_ext = '0;              w_ext[15:0] = w_lane[15:0]; end
            3'b110: begin w_ext = '0;              w_ext[31:0] = w_lane[31:0]; end
            default: w_ext = w_lane;
        endcase
    end

    // Combinational so the core holds in the very cycle the request is accepted.
    assign stall = ~reset & (w_go | (r_state == S_REQ));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_fn3     <= '0;
            r_is_load <= 1'b0;
            r_off     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            fault     <= 1'b0;
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wstrb <= '0;
`ifdef RISCV_LSU_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
        end else begin
            rd_valid <= 1'b0;
            fault    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_state   <= S_REQ;
                        r_fn3     <= fn3;
                        r_is_load <= mem_read;
                        r_off     <= w_off;
                        bus_valid <= 1'b1;
                        bus_we    <= mem_write;
                        bus_addr  <= {address[N-1:c_OW], c_OW'(0)};
                        bus_wdata <= mem_write ? w_wdata : '0;
                        bus_wstrb <= mem_write ? (w_strb << w_off) : '0;
                    end else if (w_bad) begin
                        fault <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (bus_ready) begin
                        r_state   <= S_DONE;
                        bus_valid <= 1'b0;
                        bus_we    <= 1'b0;
                        rd_valid  <= r_is_load;
                        if (r_is_load) begin
                            rd_data <= w_ext;
                        end
                    end
`ifdef RISCV_LSU_TIMEOUT_EN
                    else if (r_tmo_cnt == c_TMO_LAST) begin
                        r_state   <= S_IDLE;
                        bus_valid <= 1'b0;
                        bus_we    <= 1'b0;
                        fault     <= 1'b1;
                    end
`endif
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
`ifdef RISCV_LSU_TIMEOUT_EN
            if (r_state == S_REQ && !bus_ready && r_tmo_cnt != c_TMO_LAST) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end else begin
                r_tmo_cnt <= '0;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_lsu
// Brief    : Self-checking bench for riscv_lsu (N=32) with directed and random
//            transactions against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_lsu;
    localparam int N   = 32;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, mem_read, mem_write;
    logic [2:0]    fn3;
    logic [N-1:0]  address, rs2_data;
    logic          stall, rd_valid, fault, bus_valid, bus_ready, bus_we;
    logic [N-1:0]  rd_data, bus_addr, bus_wdata, bus_rdata;
    logic [N/8-1:0] bus_wstrb;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    riscv_lsu #(.N(N), .TIMEOUT_CYCLES(TMO)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .mem_read(mem_read),
        .mem_write(mem_write), .fn3(fn3), .address(address), .rs2_data(rs2_data),
        .stall(stall), .rd_data(rd_data), .rd_valid(rd_valid), .fault(fault),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_rdata(bus_rdata)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model, written from the ISA rules.
    function automatic int nbytes(input logic [2:0] f);
        return 1 << f[1:0];
    endfunction

    function automatic bit model_legal(input logic [2:0] f, input bit rd, input bit wr);
        if (rd && wr) return 1'b0;
        if (rd) return f inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        if (wr) return f inside {3'b000, 3'b001, 3'b010};
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int          bits = 8 * nbytes(f);
        logic [63:0] lane = {32'd0, rdata} >> (8 * (addr % 4));
        lane = lane & ((64'd1 << bits) - 1);
        if (!f[2] && lane >= (64'd1 << (bits - 1))) lane = lane - (64'd1 << bits);
        return lane[31:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f, input logic [31:0] rs2);
        case (nbytes(f))
            1:       return {24'd0, rs2[7:0]} * 32'h0101_0101;
            2:       return {16'd0, rs2[15:0]} * 32'h0001_0001;
            default: return rs2;
        endcase
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f, input logic [31:0] addr);
        int m = ((1 << nbytes(f)) - 1) << (addr % 4);
        return m[3:0];
    endfunction

    task automatic run_txn(input string name, input logic [2:0] f, input bit rd, input bit wr,
                           input logic [31:0] addr, input logic [31:0] rs2,
                           input logic [31:0] rdata, input int delay);
        bit go  = model_legal(f, rd, wr) && ((addr % nbytes(f)) == 0);
        bit bad = (rd || wr) && !go;
        @(negedge clk);
        req_valid = 1'b1; mem_read = rd; mem_write = wr; fn3 = f;
        address = addr; rs2_data = rs2;
        bus_ready = 1'($urandom); bus_rdata = $urandom;
        #1 check_eq({name, ".stall_acc"}, stall, go);
        if (!go) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            check_eq({name, ".fault"}, fault, bad);
            check_eq({name, ".bus_valid_idle"}, bus_valid, 0);
            check_eq({name, ".rd_valid_idle"}, rd_valid, 0);
            check_eq({name, ".stall_idle"}, stall, 0);
            return;
        end
        for (int k = 0; k <= delay; k++) begin
            @(negedge clk);
            req_valid = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
            fn3 = 3'($urandom); address = $urandom; rs2_data = $urandom;
            bus_ready = (k == delay);
            bus_rdata = (k == delay) ? rdata : $urandom;
            #1;
            check_eq({name, ".bus_valid"}, bus_valid, 1);
            check_eq({name, ".bus_we"}, bus_we, wr);
            check_eq({name, ".bus_addr"}, bus_addr, addr & ~32'd3);
            check_eq({name, ".bus_wstrb"}, bus_wstrb, wr ? model_strb(f, addr) : 4'd0);
            if (wr) check_eq({name, ".bus_wdata"}, bus_wdata, model_wdata(f, rs2));
            check_eq({name, ".stall_req"}, stall, 1);
            check_eq({name, ".rd_valid_req"}, rd_valid, 0);
            check_eq({name, ".fault_req"}, fault, 0);
        end
        @(negedge clk);
        req_valid = 1'b0; bus_ready = 1'b0;
        #1;
        check_eq({name, ".bus_valid_done"}, bus_valid, 0);
        check_eq({name, ".stall_done"}, stall, 0);
        check_eq({name, ".rd_valid_done"}, rd_valid, rd);
        check_eq({name, ".fault_done"}, fault, 0);
        if (rd) check_eq({name, ".rd_data"}, rd_data, model_load(f, addr, rdata));
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; fn3 = 3'd0;
        address = '0; rs2_data = '0; bus_ready = 1'b0; bus_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst.stall", stall, 0);
        check_eq("rst.rd_valid", rd_valid, 0);
        check_eq("rst.fault", fault, 0);
        check_eq("rst.bus_valid", bus_valid, 0);
        check_eq("rst.bus_we", bus_we, 0);
        check_eq("rst.rd_data", rd_data, 0);
        check_eq("rst.bus_addr", bus_addr, 0);
        check_eq("rst.bus_wdata", bus_wdata, 0);
        check_eq("rst.bus_wstrb", bus_wstrb, 0);
        reset = 1'b0;

        run_txn("lw100", 3'b010, 1, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
        run_txn("lb103", 3'b000, 1, 0, 32'h103, 32'h0, 32'h80FF_0000, 0);
        check_eq("lb103.value", rd_data, 32'hFFFF_FF80);
        run_txn("lbu103", 3'b100, 1, 0, 32'h103, 32'h0, 32'h80FF_0000, 1);
        check_eq("lbu103.value", rd_data, 32'h0000_0080);
        run_txn("sh22", 3'b001, 0, 1, 32'h22, 32'h1234_ABCD, 32'h0, 3);
        run_txn("lw102", 3'b010, 1, 0, 32'h102, 32'h0, 32'h0, 0);
        run_txn("fn3_111", 3'b111, 1, 0, 32'h100, 32'h0, 32'h0, 0);
        run_txn("rw_both", 3'b010, 1, 1, 32'h100, 32'h0, 32'h0, 0);
        run_txn("no_op", 3'b010, 0, 0, 32'h100, 32'h0, 32'h0, 0);
        run_txn("lhu_hi", 3'b101, 1, 0, 32'h2, 32'h0, 32'h8001_7FFF, 2);
        run_txn("sb3", 3'b000, 0, 1, 32'h3, 32'h0000_00A5, 32'h0, 0);

`ifdef RISCV_LSU_TIMEOUT_EN
        @(negedge clk);
        req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; fn3 = 3'b010;
        address = 32'h200; bus_ready = 1'b0;
        #1 check_eq("tmo.stall_acc", stall, 1);
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            check_eq("tmo.bus_valid", bus_valid, 1);
            check_eq("tmo.fault_wait", fault, 0);
        end
        @(negedge clk);
        #1;
        check_eq("tmo.bus_valid_drop", bus_valid, 0);
        check_eq("tmo.fault", fault, 1);
        check_eq("tmo.stall", stall, 0);
        check_eq("tmo.rd_valid", rd_valid, 0);
        @(negedge clk);
        #1 check_eq("tmo.fault_pulse", fault, 0);
`else
        run_txn("hang", 3'b010, 1, 0, 32'h200, 32'h0, 32'h1357_9BDF, 20);
`endif

        // Reset in the second REQ cycle abandons the access.
        @(negedge clk);
        req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; fn3 = 3'b010;
        address = 32'h300; bus_ready = 1'b0;
        #1 check_eq("rstreq.stall_acc", stall, 1);
        @(negedge clk);
        req_valid = 1'b0;
        #1 check_eq("rstreq.bus_valid1", bus_valid, 1);
        @(negedge clk);
        reset = 1'b1;
        #1 check_eq("rstreq.stall_in_rst", stall, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rstreq.bus_valid", bus_valid, 0);
        check_eq("rstreq.stall", stall, 0);
        check_eq("rstreq.rd_valid", rd_valid, 0);
        check_eq("rstreq.fault", fault, 0);
        @(negedge clk);
        #1;
        check_eq("rstreq.rd_valid2", rd_valid, 0);
        check_eq("rstreq.fault2", fault, 0);
        run_txn("lw_after_rst", 3'b010, 1, 0, 32'h400, 32'h0, 32'hCAFE_F00D, 0);

        for (int i = 0; i < 80; i++) begin
            logic [1:0]  rw   = 2'($urandom);
            logic [31:0] addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'd3 | ($urandom_range(0, 1) ? 32'd0 : 32'd2);
            run_txn("rand", 3'($urandom), rw[0], rw[1], addr, $urandom, $urandom,
                    $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
